// File: rtl/bound_flasher_gen_if.sv
// Panel-side bundle for bound_flasher_gen: control requests in, lamp bar and status out.
// The master drives flick/hold/auto_repeat; the flasher (slave) drives the rest.
interface bound_flasher_gen_if #(
    parameter int NUM_LAMPS = 16
) ();
    localparam int LW = $clog2(NUM_LAMPS + 1);

    logic                 flick;
    logic                 hold;
    logic                 auto_repeat;
    logic [NUM_LAMPS-1:0] lamp;
    logic [LW-1:0]        level;
    logic [2:0]           state;
    logic                 busy;
    logic                 cycle_done;

    modport master (
        output flick, hold, auto_repeat,
        input  lamp, level, state, busy, cycle_done
    );

    modport slave (
        input  flick, hold, auto_repeat,
        output lamp, level, state, busy, cycle_done
    );
endinterface

// File: rtl/bound_flasher_gen.sv
// Six-phase up/down thermometer lamp sequencer with flick kickback, hold,
// auto-repeat and an end-of-sequence pulse; one lamp step per clock.
module bound_flasher_gen #(
    parameter int NUM_LAMPS = 16,
    parameter int B1        = 5,
    parameter int B2        = 10
) (
    input  logic                clk,
    input  logic                rst,
    bound_flasher_gen_if.slave  bus
);
    localparam int LW = $clog2(NUM_LAMPS + 1);

    if (NUM_LAMPS < 4 || NUM_LAMPS > 64 || B1 < 1 || B1 >= B2 || B2 >= NUM_LAMPS - 1) begin : g_bad_params
        $error("bound_flasher_gen: illegal NUM_LAMPS/B1/B2 combination");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP_TOP  = 3'd1,
        DN_B1   = 3'd2,
        UP_B2   = 3'd3,
        DN_ZERO = 3'd4,
        UP_B1   = 3'd5,
        DN_END  = 3'd6
    } state_e;

    localparam logic [LW-1:0] LVL_TOP = LW'(NUM_LAMPS);
    localparam logic [LW-1:0] LVL_B1  = LW'(B1);
    localparam logic [LW-1:0] LVL_B1P = LW'(B1 + 1);
    localparam logic [LW-1:0] LVL_B2P = LW'(B2 + 1);

    state_e               state_q, state_d;
    logic [LW-1:0]        level_q, level_d;
    logic [NUM_LAMPS-1:0] lamp_q, lamp_d;
    logic                 busy_q, busy_d;
    logic                 cycle_done_q, cycle_done_d;

    logic          frozen;
    logic [LW-1:0] level_up, level_dn;

    assign frozen   = bus.hold && (state_q != IDLE);
    // Saturating steps keep level inside 0..N whatever the phase.
    assign level_up = (level_q == LVL_TOP) ? level_q : level_q + 1'b1;
    assign level_dn = (level_q == '0)      ? level_q : level_q - 1'b1;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            level_q      <= '0;
            lamp_q       <= '0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lamp_q       <= lamp_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // Next-state and next-level logic
    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_d = state_q;
        level_d = level_q;
        if (!frozen) begin
            unique case (state_q)
                IDLE: begin
                    level_d = '0;
                    if (bus.flick) state_d = UP_TOP;
                end
                UP_TOP: begin
                    level_d = level_up;
                    if (level_up == LVL_TOP) state_d = DN_B1;
                end
                DN_B1: begin
                    level_d = level_dn;
                    if (level_dn == LVL_B1) state_d = bus.flick ? UP_TOP : UP_B2;
                end
                UP_B2: begin
                    level_d = level_up;
                    if (level_up == LVL_B2P) state_d = DN_ZERO;
                end
                DN_ZERO: begin
                    level_d = level_dn;
                    // Kickback at B1 or 0 outranks the normal advance at 0.
                    if (bus.flick && (level_dn == LVL_B1 || level_dn == '0)) state_d = UP_B2;
                    else if (level_dn == '0)                                 state_d = UP_B1;
                end
                UP_B1: begin
                    level_d = level_up;
                    if (level_up == LVL_B1P) state_d = DN_END;
                end
                DN_END: begin
                    level_d = level_dn;
                    if (level_dn == '0) state_d = bus.auto_repeat ? UP_TOP : IDLE;
                end
                default: begin
                    state_d = IDLE;
                    level_d = '0;
                end
            endcase
        end
    end

    // Output logic: everything is derived from the next state so outputs leave flops.
    always_comb begin
        for (int i = 0; i < NUM_LAMPS; i++) begin
            lamp_d[i] = (i < int'(level_d));
        end
        busy_d       = (state_d != IDLE);
        cycle_done_d = !frozen && (state_q == DN_END) && (level_q == LW'(1));
    end

    assign bus.lamp       = lamp_q;
    assign bus.level      = level_q;
    assign bus.state      = state_q;
    assign bus.busy       = busy_q;
    assign bus.cycle_done = cycle_done_q;
endmodule

// File: tb/tb_bound_flasher_gen.sv
// Directed bench for bound_flasher_gen: a vector table for the plain run plus
// hand-written sequences for kickback, hold, auto-repeat, reset and a small-N instance.
module tb_bound_flasher_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cur_edge = 0;

    always #5 clk = ~clk;

    bound_flasher_gen_if #(.NUM_LAMPS(16)) bus ();
    bound_flasher_gen_if #(.NUM_LAMPS(8))  bus8 ();

    bound_flasher_gen #(.NUM_LAMPS(16), .B1(5), .B2(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bound_flasher_gen #(.NUM_LAMPS(8), .B1(2), .B2(5)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    typedef struct {
        int          edge_no;
        logic [15:0] lamp;
        logic [2:0]  state;
        logic        busy;
        logic        cycle_done;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cur_edge);
        end
    endtask

    // Advance one rising edge and settle; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        cur_edge++;
    endtask

    task automatic run_to(input int e);
        while (cur_edge < e) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Flick for exactly one edge; that edge becomes E0.
    task automatic start_seq();
        bus.flick = 1'b1;
        step();
        bus.flick = 1'b0;
        cur_edge  = 0;
    endtask

    task automatic check_out(input string name, input logic [15:0] lamp, input logic [2:0] state);
        check({name, ".lamp"},  64'(bus.lamp),  64'(lamp));
        check({name, ".state"}, 64'(bus.state), 64'(state));
    endtask

    initial begin
        bit saw_done;
        int done_edge;
        logic [7:0] peak;

        bus.flick = 1'b0; bus.hold = 1'b0; bus.auto_repeat = 1'b0;
        bus8.flick = 1'b0; bus8.hold = 1'b0; bus8.auto_repeat = 1'b0;

        vecs[0] = '{0,  16'h0000, 3'd1, 1'b1, 1'b0};
        vecs[1] = '{1,  16'h0001, 3'd1, 1'b1, 1'b0};
        vecs[2] = '{16, 16'hFFFF, 3'd2, 1'b1, 1'b0};
        vecs[3] = '{27, 16'h001F, 3'd3, 1'b1, 1'b0};
        vecs[4] = '{33, 16'h07FF, 3'd4, 1'b1, 1'b0};
        vecs[5] = '{44, 16'h0000, 3'd5, 1'b1, 1'b0};
        vecs[6] = '{50, 16'h003F, 3'd6, 1'b1, 1'b0};
        vecs[7] = '{56, 16'h0000, 3'd0, 1'b0, 1'b1};
        vecs[8] = '{57, 16'h0000, 3'd0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        check_out("reset", 16'h0000, 3'd0);
        check("reset.level", 64'(bus.level), 64'd0);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.cycle_done", 64'(bus.cycle_done), 64'd0);

        // Normal run from the vector table
        start_seq();
        foreach (vecs[i]) begin
            run_to(vecs[i].edge_no);
            check_out($sformatf("normal_E%0d", vecs[i].edge_no), vecs[i].lamp, vecs[i].state);
            check($sformatf("normal_E%0d.busy", vecs[i].edge_no), 64'(bus.busy), 64'(vecs[i].busy));
            check($sformatf("normal_E%0d.cycle_done", vecs[i].edge_no),
                  64'(bus.cycle_done), 64'(vecs[i].cycle_done));
        end

        // flick held high: bounces between top and B1, never completes
        do_reset();
        bus.flick = 1'b1;
        step();
        cur_edge = 0;
        saw_done = 1'b0;
        while (cur_edge < 60) begin
            step();
            if (bus.cycle_done) saw_done = 1'b1;
            if (cur_edge == 27) check_out("flick_held_E27", 16'h001F, 3'd1);
            if (cur_edge == 38) check_out("flick_held_E38", 16'hFFFF, 3'd2);
            if (cur_edge == 49) check_out("flick_held_E49", 16'h001F, 3'd1);
        end
        check("flick_held.no_cycle_done", 64'(saw_done), 64'd0);
        bus.flick = 1'b0;

        // DN_ZERO kickback at level B1 (E39)
        do_reset();
        start_seq();
        run_to(38);
        bus.flick = 1'b1;
        step();
        bus.flick = 1'b0;
        check_out("kick_b1_E39", 16'h001F, 3'd3);
        run_to(45);
        check_out("kick_b1_E45", 16'h07FF, 3'd4);

        // DN_ZERO kickback at level 0 (E44)
        do_reset();
        start_seq();
        run_to(43);
        bus.flick = 1'b1;
        step();
        bus.flick = 1'b0;
        check_out("kick_0_E44", 16'h0000, 3'd3);
        run_to(55);
        check_out("kick_0_E55", 16'h07FF, 3'd4);

        // hold in UP_TOP at level 8, then hold with flick at a DN_B1 kickback point
        do_reset();
        bus.hold = 1'b1;
        start_seq();
        check("hold_idle.state", 64'(bus.state), 64'd1);
        bus.hold = 1'b0;
        run_to(8);
        bus.hold = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.flick = i[0];
            step();
            check_out($sformatf("hold_up_%0d", i), 16'h00FF, 3'd1);
            check($sformatf("hold_up_%0d.cycle_done", i), 64'(bus.cycle_done), 64'd0);
        end
        bus.hold = 1'b0;
        bus.flick = 1'b0;
        run_to(33);
        check_out("hold_dn_pre", 16'h003F, 3'd2);
        bus.hold = 1'b1;
        bus.flick = 1'b1;
        step();
        step();
        check_out("hold_dn_frozen", 16'h003F, 3'd2);
        bus.hold = 1'b0;
        bus.flick = 1'b0;
        step();
        check_out("hold_dn_release", 16'h001F, 3'd3);
        run_to(64);
        check_out("hold_late_E64", 16'h0001, 3'd6);
        check("hold_late_E64.cycle_done", 64'(bus.cycle_done), 64'd0);
        step();
        check_out("hold_late_E65", 16'h0000, 3'd0);
        check("hold_late_E65.cycle_done", 64'(bus.cycle_done), 64'd1);

        // auto_repeat restart, then one-edge reset mid DN_B1
        do_reset();
        bus.auto_repeat = 1'b1;
        start_seq();
        run_to(56);
        check_out("auto_E56", 16'h0000, 3'd1);
        check("auto_E56.cycle_done", 64'(bus.cycle_done), 64'd1);
        step();
        bus.auto_repeat = 1'b0;
        check_out("auto_E57", 16'h0001, 3'd1);
        check("auto_E57.cycle_done", 64'(bus.cycle_done), 64'd0);
        run_to(76);
        check_out("auto_E76", 16'h0FFF, 3'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("mid_reset", 16'h0000, 3'd0);
        check("mid_reset.busy", 64'(bus.busy), 64'd0);
        for (int i = 0; i < 5; i++) step();
        check_out("mid_reset_stays_idle", 16'h0000, 3'd0);

        // N=8, B1=2, B2=5: 2N + 2*B2 + 4 = 30 edges, peak 0xFF
        bus8.flick = 1'b1;
        step();
        bus8.flick = 1'b0;
        check("sweep_E0.busy", 64'(bus8.busy), 64'd1);
        peak = '0;
        done_edge = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            peak = peak | bus8.lamp;
            if (!bus8.busy) begin
                done_edge = i;
                break;
            end
        end
        check("sweep.length", 64'(done_edge), 64'd30);
        check("sweep.peak", 64'(peak), 64'hFF);
        check("sweep.cycle_done", 64'(bus8.cycle_done), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
